// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the execute-stage branch logic.
//   XLEN        datapath / PC width
//   bpOp_t      branch operation encoding carried from decode (BpCtl)
//   ST_*        squash FSM state encoding
//   isBranch()  true for any op that resolves as a branch
package mips_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    BP_NONE = 3'b000,
    BP_BEQ  = 3'b001,
    BP_BNE  = 3'b010,
    BP_BLEZ = 3'b011,
    BP_BGTZ = 3'b100,
    BP_BLTZ = 3'b101,
    BP_BGEZ = 3'b110,
    BP_JR   = 3'b111
  } bpOp_t;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_SQUASH1 = 1'b1;

  function automatic logic isBranch(bpOp_t op);
    return op != BP_NONE;
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// branch_resolve_if: decode -> EX branch fields and EX -> fetch/decode
// redirect, kill and link results.
//   master : decode/fetch side (drives the *_ID fields, receives results)
//   slave  : branch_resolve
interface branch_resolve_if #(parameter int XLEN = mips_pkg::XLEN);

  logic            Valid_ID;
  logic [2:0]      BpCtl_ID;
  logic            Link_ID;
  logic [XLEN-1:0] PcPlus4_ID;
  logic [15:0]     Imm_ID;
  logic [XLEN-1:0] RsData_ID;
  logic [XLEN-1:0] RtData_ID;

  logic            BranchTaken_EX;
  logic [XLEN-1:0] RedirectPc_EX;
  logic            Kill_ID;
  logic            LinkValid_EX;
  logic [XLEN-1:0] LinkData_EX;
  logic            AddrErr_EX;

  modport master (
    output Valid_ID, BpCtl_ID, Link_ID, PcPlus4_ID, Imm_ID, RsData_ID, RtData_ID,
    input  BranchTaken_EX, RedirectPc_EX, Kill_ID, LinkValid_EX, LinkData_EX, AddrErr_EX
  );

  modport slave (
    input  Valid_ID, BpCtl_ID, Link_ID, PcPlus4_ID, Imm_ID, RsData_ID, RtData_ID,
    output BranchTaken_EX, RedirectPc_EX, Kill_ID, LinkValid_EX, LinkData_EX, AddrErr_EX
  );

endinterface

// File: rtl/branch_cond.sv
// branch_cond: purely combinational branch condition evaluator.
//   bpCtl  branch operation
//   rs, rt operands
//   taken  condition holds (JR always taken, BP_NONE never)
module branch_cond #(
  parameter int XLEN = mips_pkg::XLEN
) (
  input  mips_pkg::bpOp_t bpCtl,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] rt,
  output logic            taken
);
  import mips_pkg::*;

  logic rsNeg;
  logic rsZero;

  assign rsNeg  = rs[XLEN-1];
  assign rsZero = (rs == '0);

  always_comb begin
    taken = 1'b0;
    case (bpCtl)
      BP_BEQ:  taken = (rs == rt);
      BP_BNE:  taken = (rs != rt);
      BP_BLEZ: taken = rsNeg | rsZero;
      BP_BGTZ: taken = ~rsNeg & ~rsZero;
      BP_BLTZ: taken = rsNeg;
      BP_BGEZ: taken = ~rsNeg;
      BP_JR:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/dff.sv
// dff: W-bit register, asynchronous active-low reset to zero.
//   clk, reset : clock / async active-low reset
//   d, q       : data in / registered data out
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: execute-stage branch resolution.
//   clk, reset  clock / asynchronous active-low reset
//   AnyStall    global stall; EX register holds and no strobe/link/count
//   br          slave side of branch_resolve_if (ID fields in, redirect,
//               kill, link and address-error results out)
//   BrCount     saturating count of resolved branches
//   TakenCount  saturating count of issued redirects
module branch_resolve #(
  parameter int XLEN  = mips_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             AnyStall,
  branch_resolve_if.slave  br,
  output logic [CNT_W-1:0] BrCount,
  output logic [CNT_W-1:0] TakenCount
);
  import mips_pkg::*;

  // ID/EX register
  logic            exValid;
  bpOp_t           exBpCtl;
  logic            exLink;
  logic [XLEN-1:0] exPcPlus4;
  logic [15:0]     exImm;
  logic [XLEN-1:0] exRs;
  logic [XLEN-1:0] exRt;

  logic [0:0] state;
  logic [0:0] stateNext;
  logic       killId;

  assign killId = (state == ST_SQUASH1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exValid   <= 1'b0;
      exBpCtl   <= BP_NONE;
      exLink    <= 1'b0;
      exPcPlus4 <= '0;
      exImm     <= '0;
      exRs      <= '0;
      exRt      <= '0;
    end else if (!AnyStall) begin
      // the wrong-path word sitting in ID while squashing enters EX as a bubble
      exValid   <= br.Valid_ID & ~killId;
      exBpCtl   <= bpOp_t'(br.BpCtl_ID);
      exLink    <= br.Link_ID;
      exPcPlus4 <= br.PcPlus4_ID;
      exImm     <= br.Imm_ID;
      exRs      <= br.RsData_ID;
      exRt      <= br.RtData_ID;
    end
  end

  logic            condTaken;
  logic            addrErr;
  logic            branchTaken;
  logic            linkValid;
  logic [XLEN-1:0] branchOff;
  logic [XLEN-1:0] target;

  branch_cond #(.XLEN(XLEN)) uCond (
    .bpCtl (exBpCtl),
    .rs    (exRs),
    .rt    (exRt),
    .taken (condTaken)
  );

  // word offset, sign extended and scaled to bytes; wrap-around is allowed
  assign branchOff = {{(XLEN-18){exImm[15]}}, exImm, 2'b00};
  assign target    = (exBpCtl == BP_JR) ? exRs : exPcPlus4 + branchOff;

  assign addrErr     = exValid & (exBpCtl == BP_JR) & (exRs[1:0] != 2'b00);
  // strobe only in the cycle the branch actually leaves EX
  assign branchTaken = exValid & condTaken & ~AnyStall & ~addrErr;
  // link write is independent of the outcome (BLTZAL/BGEZAL)
  assign linkValid   = exValid & exLink & ~AnyStall;

  assign br.BranchTaken_EX = branchTaken;
  assign br.RedirectPc_EX  = branchTaken ? target : '0;
  assign br.Kill_ID        = killId;
  assign br.LinkValid_EX   = linkValid;
  assign br.LinkData_EX    = linkValid ? exPcPlus4 + XLEN'(4) : '0;
  assign br.AddrErr_EX     = addrErr;

  // Squash FSM: the delay slot is in ID during the redirect cycle and is
  // kept; the word fetched in the redirect cycle lands in ID next and is
  // killed until it is consumed by a non-stalled edge.
  always_comb begin
    stateNext = state;
    if (state == ST_IDLE) begin
      if (branchTaken) stateNext = ST_SQUASH1;
    end else begin
      if (!AnyStall) stateNext = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= stateNext;
  end

  // Saturating statistics: index 0 = resolved branches, 1 = redirects
  logic [1:0]       cntInc;
  logic [CNT_W-1:0] cntQ [2];
  logic [CNT_W-1:0] cntD [2];

  assign cntInc[0] = ~AnyStall & exValid & isBranch(exBpCtl);
  assign cntInc[1] = branchTaken;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gCnt
      assign cntD[gi] = (cntInc[gi] && (cntQ[gi] != '1)) ? cntQ[gi] + 1'b1 : cntQ[gi];
      dff #(.W(CNT_W)) uCnt (
        .clk   (clk),
        .reset (reset),
        .d     (cntD[gi]),
        .q     (cntQ[gi])
      );
    end
  endgenerate

  assign BrCount    = cntQ[0];
  assign TakenCount = cntQ[1];

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: table vectors, hand-written stall/squash/saturation/
// reset sequences and randomized traffic checked against a behavioural
// model. A second instance with 2-bit counters shares all stimulus.
module tb_branch_resolve;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic AnyStall = 1'b0;

  always #5 clk = ~clk;

  branch_resolve_if #(.XLEN(XLEN)) ifA ();
  branch_resolve_if #(.XLEN(XLEN)) ifB ();

  logic [15:0] brCntA, tkCntA;
  logic [1:0]  brCntB, tkCntB;

  assign ifB.Valid_ID   = ifA.Valid_ID;
  assign ifB.BpCtl_ID   = ifA.BpCtl_ID;
  assign ifB.Link_ID    = ifA.Link_ID;
  assign ifB.PcPlus4_ID = ifA.PcPlus4_ID;
  assign ifB.Imm_ID     = ifA.Imm_ID;
  assign ifB.RsData_ID  = ifA.RsData_ID;
  assign ifB.RtData_ID  = ifA.RtData_ID;

  branch_resolve #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .AnyStall(AnyStall), .br(ifA),
    .BrCount(brCntA), .TakenCount(tkCntA)
  );

  branch_resolve #(.XLEN(XLEN), .CNT_W(2)) dutSmall (
    .clk(clk), .reset(reset), .AnyStall(AnyStall), .br(ifB),
    .BrCount(brCntB), .TakenCount(tkCntB)
  );

  typedef struct packed {
    logic        valid;
    logic [2:0]  op;
    logic        link;
    logic [31:0] pc4;
    logic [15:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        stall;
  } inVec_t;

  typedef struct packed {
    inVec_t      in;
    logic        expTaken;
    logic [31:0] expPc;
    logic        expLv;
    logic [31:0] expLd;
    logic        expAe;
  } tabVec_t;

  tabVec_t tab [11];

  // model state
  inVec_t mEx;
  bit     mKill;
  int     mBr, mTk;

  int nVec = 0, nErr = 0, strobes = 0, killCycles = 0;

  function automatic inVec_t mkIn(logic [2:0] op, logic link, logic [31:0] pc4,
                                  logic [15:0] imm, logic [31:0] rs, logic [31:0] rt);
    inVec_t v;
    v.valid = 1'b1; v.op = op; v.link = link; v.pc4 = pc4;
    v.imm = imm; v.rs = rs; v.rt = rt; v.stall = 1'b0;
    return v;
  endfunction

  function automatic tabVec_t mkTab(inVec_t in, logic tk, logic [31:0] pc,
                                    logic lv, logic [31:0] ld, logic ae);
    tabVec_t t;
    t.in = in; t.expTaken = tk; t.expPc = pc; t.expLv = lv; t.expLd = ld; t.expAe = ae;
    return t;
  endfunction

  function automatic bit mTaken(logic [2:0] op, logic [31:0] rs, logic [31:0] rt);
    case (op)
      3'd1: return rs == rt;
      3'd2: return rs != rt;
      3'd3: return $signed(rs) <= 0;
      3'd4: return $signed(rs) > 0;
      3'd5: return $signed(rs) < 0;
      3'd6: return $signed(rs) >= 0;
      3'd7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] mTarget(inVec_t e);
    int off;
    if (e.op == 3'd7) return e.rs;
    off = int'($signed(e.imm));
    return e.pc4 + 32'(off * 4);
  endfunction

  function automatic logic [31:0] sat(int c, int mx);
    return (c > mx) ? 32'(mx) : 32'(c);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input inVec_t v);
    ifA.Valid_ID   = v.valid;
    ifA.BpCtl_ID   = v.op;
    ifA.Link_ID    = v.link;
    ifA.PcPlus4_ID = v.pc4;
    ifA.Imm_ID     = v.imm;
    ifA.RsData_ID  = v.rs;
    ifA.RtData_ID  = v.rt;
    AnyStall       = v.stall;
  endtask

  // One clock: drive v, check at the falling edge, advance model on the rising edge.
  task automatic step(input inVec_t v, input int tabIdx);
    logic expTk, expLv, expAe;
    logic [31:0] expPc, expLd;
    inVec_t nextEx;
    drive(v);
    @(negedge clk);
    expAe = mEx.valid && mEx.op == 3'd7 && (mEx.rs % 4 != 0);
    expTk = mEx.valid && mTaken(mEx.op, mEx.rs, mEx.rt) && !v.stall && !expAe;
    expPc = expTk ? mTarget(mEx) : 32'h0;
    expLv = mEx.valid && mEx.link && !v.stall;
    expLd = expLv ? mEx.pc4 + 32'd4 : 32'h0;
    chk("taken",      32'(ifA.BranchTaken_EX), 32'(expTk));
    chk("redirect",   ifA.RedirectPc_EX, expPc);
    chk("kill",       32'(ifA.Kill_ID), 32'(mKill));
    chk("linkValid",  32'(ifA.LinkValid_EX), 32'(expLv));
    chk("linkData",   ifA.LinkData_EX, expLd);
    chk("addrErr",    32'(ifA.AddrErr_EX), 32'(expAe));
    chk("brCount",    32'(brCntA), sat(mBr, 65535));
    chk("takenCount", 32'(tkCntA), sat(mTk, 65535));
    chk("brCount2",   32'(brCntB), sat(mBr, 3));
    chk("takenCount2",32'(tkCntB), sat(mTk, 3));
    if (tabIdx >= 0) begin
      chk($sformatf("tab%0d.taken", tabIdx), 32'(ifA.BranchTaken_EX), 32'(tab[tabIdx].expTaken));
      chk($sformatf("tab%0d.pc", tabIdx), ifA.RedirectPc_EX, tab[tabIdx].expPc);
      chk($sformatf("tab%0d.lv", tabIdx), 32'(ifA.LinkValid_EX), 32'(tab[tabIdx].expLv));
      chk($sformatf("tab%0d.ld", tabIdx), ifA.LinkData_EX, tab[tabIdx].expLd);
      chk($sformatf("tab%0d.ae", tabIdx), 32'(ifA.AddrErr_EX), 32'(tab[tabIdx].expAe));
    end
    if (ifA.BranchTaken_EX) strobes++;
    if (ifA.Kill_ID) killCycles++;
    $display("cyc t=%0t op=%0d v=%0b st=%0b tk=%0b pc=%h kill=%0b br=%0d tk#=%0d",
             $time, v.op, v.valid, v.stall, ifA.BranchTaken_EX, ifA.RedirectPc_EX,
             ifA.Kill_ID, brCntA, tkCntA);
    nextEx = v;
    nextEx.valid = v.valid && !mKill;
    @(posedge clk);
    if (!v.stall) begin
      if (mEx.valid && mEx.op != 3'd0) mBr++;
      if (expTk) mTk++;
    end
    mKill = mKill ? v.stall : expTk;
    if (!v.stall) mEx = nextEx;
    #1;
  endtask

  // Assert reset mid-cycle; every output must drop at once.
  task automatic doReset();
    inVec_t idle;
    idle = '0;
    drive(idle);
    #2 reset = 1'b0;
    #1;
    chk("rst.taken",  32'(ifA.BranchTaken_EX), 32'h0);
    chk("rst.pc",     ifA.RedirectPc_EX, 32'h0);
    chk("rst.kill",   32'(ifA.Kill_ID), 32'h0);
    chk("rst.lv",     32'(ifA.LinkValid_EX), 32'h0);
    chk("rst.ld",     ifA.LinkData_EX, 32'h0);
    chk("rst.ae",     32'(ifA.AddrErr_EX), 32'h0);
    chk("rst.br",     32'(brCntA), 32'h0);
    chk("rst.tk",     32'(tkCntA), 32'h0);
    chk("rst.br2",    32'(brCntB), 32'h0);
    chk("rst.tk2",    32'(tkCntB), 32'h0);
    $display("reset t=%0t", $time);
    mEx = '0; mKill = 1'b0; mBr = 0; mTk = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    inVec_t nop, beqT, v;
    nop  = mkIn(3'd0, 1'b0, 32'h400, 16'h0, 32'h0, 32'h0);
    beqT = mkIn(3'd1, 1'b0, 32'h100, 16'h0003, 32'h5, 32'h5);

    tab[0]  = mkTab(beqT, 1'b1, 32'h10C, 1'b0, 32'h0, 1'b0);
    tab[1]  = mkTab(mkIn(3'd2, 1'b0, 32'h200, 16'h0010, 32'h7, 32'h7), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tab[2]  = mkTab(mkIn(3'd4, 1'b0, 32'h200, 16'h0010, 32'h80000000, 32'h0), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tab[3]  = mkTab(mkIn(3'd5, 1'b0, 32'h0, 16'hFFFF, 32'h80000000, 32'h0), 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0, 1'b0);
    tab[4]  = mkTab(mkIn(3'd5, 1'b1, 32'h0, 16'hFFFF, 32'h80000000, 32'h0), 1'b1, 32'hFFFFFFFC, 1'b1, 32'h4, 1'b0);
    tab[5]  = mkTab(mkIn(3'd7, 1'b0, 32'h300, 16'h0, 32'h2002, 32'h0), 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tab[6]  = mkTab(mkIn(3'd7, 1'b0, 32'h300, 16'h0, 32'h2000, 32'h0), 1'b1, 32'h2000, 1'b0, 32'h0, 1'b0);
    tab[7]  = mkTab(mkIn(3'd1, 1'b0, 32'h100, 16'h0003, 32'h5, 32'h6), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tab[8]  = mkTab(mkIn(3'd3, 1'b0, 32'h1000, 16'hFFFE, 32'h0, 32'h0), 1'b1, 32'hFF8, 1'b0, 32'h0, 1'b0);
    tab[9]  = mkTab(mkIn(3'd6, 1'b1, 32'h800, 16'h0001, 32'h0, 32'h0), 1'b1, 32'h804, 1'b1, 32'h804, 1'b0);
    tab[10] = mkTab(mkIn(3'd0, 1'b1, 32'h500, 16'h0004, 32'h1, 32'h1), 1'b0, 32'h0, 1'b1, 32'h504, 1'b0);

    // reset state
    doReset();

    // table vectors: capture, then check while the branch sits in EX
    for (int i = 0; i < 11; i++) begin
      step(tab[i].in, -1);
      step(nop, i);
      step(nop, -1);
      step(nop, -1);
    end

    // taken branch held in EX by a 3-cycle stall, then stall during SQUASH1
    doReset();
    strobes = 0; killCycles = 0;
    step(beqT, -1);
    v = nop; v.stall = 1'b1;
    repeat (3) step(v, -1);
    step(nop, -1);
    repeat (2) step(v, -1);
    step(nop, -1);
    step(nop, -1);
    chk("stall.strobes", 32'(strobes), 32'd1);
    chk("stall.killCycles", 32'(killCycles), 32'd3);

    // saturation of the 2-bit counters, then reset during SQUASH1
    doReset();
    for (int i = 0; i < 5; i++) begin
      step(beqT, -1);
      repeat (3) step(nop, -1);
    end
    chk("sat.br2", 32'(brCntB), 32'd3);
    chk("sat.tk2", 32'(tkCntB), 32'd3);
    chk("sat.tk16", 32'(tkCntA), 32'd5);
    step(beqT, -1);
    step(nop, -1);
    chk("presquash.kill", 32'(ifA.Kill_ID), 32'd1);
    doReset();
    strobes = 0;
    repeat (3) step(nop, -1);
    chk("postrst.strobes", 32'(strobes), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int sel;
      v.valid = ($urandom % 5) != 0;
      v.op    = 3'($urandom % 8);
      // no branch may sit in the delay slot of the branch now in EX
      if (mEx.valid && mEx.op != 3'd0) v.op = 3'd0;
      v.link  = ($urandom % 4) == 0;
      v.pc4   = $urandom & 32'hFFFFFFFC;
      v.imm   = 16'($urandom);
      sel     = $urandom % 4;
      case (sel)
        0: v.rs = $urandom;
        1: v.rs = 32'h0;
        2: v.rs = $urandom % 16;
        default: v.rs = 32'hFFFFFFF0 | ($urandom % 16);
      endcase
      v.rt    = (($urandom % 3) == 0) ? v.rs : $urandom;
      v.stall = ($urandom % 4) == 0;
      step(v, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
